// File: rtl/image_framebuffer.sv
// WIDTH x HEIGHT pixel frame store with draw/erase/load, a row-by-row
// clear sequencer, a registered read port and a flattened frame view.
module image_framebuffer #(
  parameter int WIDTH      = 16,
  parameter int HEIGHT     = 12,
  parameter int PIXEL_BITS = 2,
  parameter int X_BITS     = 4,
  parameter int Y_BITS     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               draw,
  input  logic                               erase,
  input  logic [X_BITS-1:0]                  x,
  input  logic [Y_BITS-1:0]                  y,
  input  logic [PIXEL_BITS-1:0]              color,
  input  logic                               load,
  input  logic [WIDTH*HEIGHT*PIXEL_BITS-1:0] draw_image,
  input  logic                               clear,
  output logic                               busy,
  output logic                               oob,
  input  logic [X_BITS-1:0]                  rd_x,
  input  logic [Y_BITS-1:0]                  rd_y,
  output logic [PIXEL_BITS-1:0]              rd_pixel,
  output logic [WIDTH*HEIGHT*PIXEL_BITS-1:0] image
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int IW = $clog2(N) + 1;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [Y_BITS-1:0]     r_row;
  logic                  r_oob;
  logic [PIXEL_BITS-1:0] r_rd;
  logic [PIXEL_BITS-1:0] r_mem [N];

  logic [31:0]           w_x32;
  logic [31:0]           w_y32;
  logic [31:0]           w_rx32;
  logic [31:0]           w_ry32;
  logic                  w_win;
  logic                  w_rin;
  logic [IW-1:0]         w_widx;
  logic [IW-1:0]         w_ridx;
  logic [PIXEL_BITS-1:0] w_wdata;
  logic [PIXEL_BITS-1:0] w_rdata;
  logic                  w_load;
  logic                  w_wr;
  logic                  w_oob;
  logic                  w_rowclr;

  // Range checks in 32 bits so WIDTH == 2**X_BITS cannot wrap.
  assign w_x32   = 32'(x);
  assign w_y32   = 32'(y);
  assign w_rx32  = 32'(rd_x);
  assign w_ry32  = 32'(rd_y);
  assign w_win   = (w_x32 < 32'(WIDTH)) && (w_y32 < 32'(HEIGHT));
  assign w_rin   = (w_rx32 < 32'(WIDTH)) && (w_ry32 < 32'(HEIGHT));
  assign w_widx  = IW'(w_y32 * 32'(WIDTH) + w_x32);
  assign w_ridx  = IW'(w_ry32 * 32'(WIDTH) + w_rx32);
  assign w_wdata = erase ? '0 : color;
  assign w_rowclr = (r_state == S_CLEAR);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_wr   = 1'b0;
    w_oob  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (clear) begin
          w_next = S_CLEAR;
        end else if (load) begin
          w_load = 1'b1;
        end else if (erase || draw) begin
          if (w_win) w_wr  = 1'b1;
          else       w_oob = 1'b1;
        end
      end
      S_CLEAR: begin
        if (r_row == Y_BITS'(HEIGHT - 1)) w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_oob   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_oob   <= w_oob;
      if (r_state == S_CLEAR) r_row <= r_row + 1'b1;
      else                    r_row <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_load)
          r_mem[i] <= draw_image[i*PIXEL_BITS +: PIXEL_BITS];
        else if (w_wr && (w_widx == IW'(i)))
          r_mem[i] <= w_wdata;
        else if (w_rowclr && (Y_BITS'(i / WIDTH) == r_row))
          r_mem[i] <= '0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < N; i++) begin
      if (w_rin && (w_ridx == IW'(i))) w_rdata = r_mem[i];
    end
  end

  // Samples storage before this edge's write lands: read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd <= '0;
    else     r_rd <= w_rdata;
  end

  for (genvar g = 0; g < N; g++) begin : g_view
    assign image[g*PIXEL_BITS +: PIXEL_BITS] = r_mem[g];
  end

  assign busy     = (r_state == S_CLEAR);
  assign oob      = r_oob;
  assign rd_pixel = r_rd;

endmodule

// File: tb/tb_image_framebuffer.sv
// Scoreboard bench for image_framebuffer: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_image_framebuffer;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int PB = 2;
  localparam int XB = 5;
  localparam int YB = 4;
  localparam int FB = W * H * PB;

  localparam int K_IMG  = 0;
  localparam int K_BUSY = 1;
  localparam int K_OOB  = 2;
  localparam int K_RD   = 3;

  typedef struct {
    int          kind;
    logic [FB-1:0] exp;
    string       name;
  } chk_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          draw, erase, load, clear;
  logic [XB-1:0] x, rd_x;
  logic [YB-1:0] y, rd_y;
  logic [PB-1:0] color;
  logic [FB-1:0] draw_image;
  logic          busy, oob;
  logic [PB-1:0] rd_pixel;
  logic [FB-1:0] image;

  chk_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            waited;
  logic [FB-1:0] exp_img;
  logic [FB-1:0] pat;

  always #5 clk = ~clk;

  image_framebuffer #(
    .WIDTH(W), .HEIGHT(H), .PIXEL_BITS(PB),
    .X_BITS(XB), .Y_BITS(YB)
  ) dut (
    .clk(clk), .rst(rst), .draw(draw), .erase(erase),
    .x(x), .y(y), .color(color), .load(load),
    .draw_image(draw_image), .clear(clear), .busy(busy),
    .oob(oob), .rd_x(rd_x), .rd_y(rd_y),
    .rd_pixel(rd_pixel), .image(image)
  );

  function automatic logic [FB-1:0] sample(input int k);
    case (k)
      K_IMG:  return image;
      K_BUSY: return FB'(busy);
      K_OOB:  return FB'(oob);
      default: return FB'(rd_pixel);
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t c;
      logic [FB-1:0] act;
      c = sb.pop_front();
      act = sample(c.kind);
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  task automatic expect_now(input int k, input logic [FB-1:0] e,
                            input string n);
    logic [FB-1:0] act;
    act = sample(k);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (now)", n, act, e);
    end
  endtask

  task automatic push(input int k, input logic [FB-1:0] e,
                      input string n);
    chk_t c;
    c.kind = k;
    c.exp  = e;
    c.name = n;
    sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FB-1:0] cleared_rows(input int nrows);
    logic [FB-1:0] v;
    v = '1;
    for (int r = 0; r < nrows; r++) v[r*W*PB +: W*PB] = '0;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    draw = 0; erase = 0; load = 0; clear = 0;
    x = 0; y = 0; color = 0; rd_x = 0; rd_y = 0;
    draw_image = '0;
    exp_img = '0;
    pat = {12{32'hA5C3_96F0}};

    tick(); tick();
    rst = 1'b0;
    tick();
    expect_now(K_IMG, '0, "reset_image");
    expect_now(K_BUSY, '0, "reset_busy");
    expect_now(K_OOB, '0, "reset_oob");
    expect_now(K_RD, '0, "reset_rd");

    draw = 1; x = 3; y = 2; color = 2'b11;
    rd_x = 3; rd_y = 2;
    tick();
    draw = 0;
    exp_img[71:70] = 2'b11;
    push(K_IMG, exp_img, "draw_image");
    push(K_RD, '0, "read_before_write");
    push(K_OOB, '0, "draw_no_oob");
    tick();
    push(K_RD, FB'(3), "read_after_draw");

    draw = 1; erase = 1; x = 3; y = 2; color = 2'b01;
    tick();
    draw = 0; erase = 0;
    exp_img[71:70] = 2'b00;
    push(K_IMG, exp_img, "erase_over_draw");

    load = 1; erase = 1; x = 3; y = 2; draw_image = pat;
    tick();
    load = 0; erase = 0;
    exp_img = pat;
    push(K_IMG, exp_img, "load_over_erase");
    tick();
    push(K_RD, FB'(3), "read_loaded");

    draw = 1; x = 16; y = 0; color = 2'b01;
    tick();
    draw = 0;
    push(K_OOB, FB'(1), "oob_x_pulse");
    push(K_IMG, exp_img, "oob_x_nowrite");
    tick();
    push(K_OOB, '0, "oob_x_one_cycle");

    draw = 1; x = 0; y = 12; color = 2'b01;
    tick();
    draw = 0;
    push(K_OOB, FB'(1), "oob_y_pulse");
    push(K_IMG, exp_img, "oob_y_nowrite");
    tick();
    push(K_OOB, '0, "oob_y_one_cycle");

    rd_x = 16; rd_y = 0;
    tick(); tick();
    push(K_RD, '0, "oob_read_zero");

    load = 1; draw = 1; x = 16; y = 0;
    tick();
    load = 0; draw = 0;
    push(K_OOB, '0, "oob_masked_by_load");
    push(K_IMG, exp_img, "reload_same");

    draw_image = '1; load = 1;
    tick();
    load = 0;
    push(K_IMG, '1, "load_ones");
    clear = 1;
    tick();
    clear = 0;
    for (int k = 1; k <= 12; k++) begin
      push(K_BUSY, FB'(1), "busy_high");
      push(K_IMG, cleared_rows(k - 1), "clear_progress");
      if (k == 3) begin
        draw = 1; x = 0; y = 11; color = 2'b10;
      end else if (k == 5) begin
        draw = 1; x = 16; y = 0; color = 2'b01;
      end else begin
        draw = 0;
      end
      if (k == 6) push(K_OOB, '0, "no_oob_in_clear");
      tick();
    end
    draw = 0;
    push(K_BUSY, '0, "busy_fall");
    push(K_IMG, '0, "clear_done");
    waited = 0;
    while (busy && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL busy_wait_expired: busy still high");
    end

    load = 1;
    tick();
    load = 0;
    rd_x = 15; rd_y = 11;
    clear = 1;
    tick();
    clear = 0;
    for (int k = 0; k < 4; k++) tick();
    push(K_RD, FB'(3), "rd_before_rst");
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    expect_now(K_BUSY, '0, "async_rst_busy");
    expect_now(K_IMG, '0, "async_rst_image");
    expect_now(K_RD, '0, "async_rst_rd");
    tick();
    rst = 1'b0;
    draw = 1; x = 15; y = 11; color = 2'b01;
    tick();
    draw = 0;
    exp_img = '0;
    exp_img[383:382] = 2'b01;
    push(K_IMG, exp_img, "draw_after_rst");
    push(K_BUSY, '0, "idle_after_rst");
    tick();
    push(K_RD, FB'(1), "read_after_rst");

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
